fifo_v1: RTL and testbench

- Single-clock synchronous FIFO, data width W, depth 2**N words.
- Show-ahead (first-word-fall-through) read: the head word is always presented on rd while the FIFO is not empty.
- General-purpose buffer between a producer and consumer in the same clock domain. It provides empty/full/level status, and overflow/underflow attempts are ignored safely.

---
 rtl/fifo_v1_pkg.sv | 6 +
 rtl/fifo_v1_ram.sv | 25 ++
 rtl/fifo_v1.sv | 77 +++++++
 tb/tb_fifo_v1.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/fifo_v1_pkg.sv
// Shared defaults for the fifo_v1 slice: word width and address width.
// Optional sticky error flags are enabled by defining FIFO_ERR_FLAGS_EN.
package fifo_v1_pkg;
    localparam int FIFO_DEF_W = 8;
    localparam int FIFO_DEF_N = 4;
endpackage

// File: rtl/fifo_v1_ram.sv
// Storage array for fifo_v1: 2**N x W, synchronous write port, asynchronous read port.
// Contents are never reset; the pointers in the parent decide what is valid.
module fifo_v1_ram
    import fifo_v1_pkg::*;
#(
    parameter int W = FIFO_DEF_W,
    parameter int N = FIFO_DEF_N
) (
    input  logic         clk,
    input  logic         we,
    input  logic [N-1:0] wa,
    input  logic [W-1:0] wd,
    input  logic [N-1:0] ra,
    output logic [W-1:0] rd
);
    logic [W-1:0] mem [2**N];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
    end

    assign rd = mem[ra];
endmodule

// File: rtl/fifo_v1.sv
// Single-clock show-ahead FIFO with empty/full/level status.
// Define FIFO_ERR_FLAGS_EN to add sticky ovf/udf outputs.
module fifo_v1
    import fifo_v1_pkg::*;
#(
    parameter int W = FIFO_DEF_W,
    parameter int N = FIFO_DEF_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         we,
    input  logic [W-1:0] wd,
    input  logic         re,
    output logic [W-1:0] rd,
    output logic         empty,
    output logic         full,
`ifdef FIFO_ERR_FLAGS_EN
    output logic         ovf,
    output logic         udf,
`endif
    output logic [N:0]   level
);
    localparam int PW = N + 1;

    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          wa;
    logic          ra;

    // Request/accept contract: a write is taken when we=1 and there is room
    // (or a read frees a slot in the same cycle); a read is taken when re=1
    // and a word is present. Requests that are not taken are dropped silently.
    assign empty = (wptr == rptr);
    assign full  = (wptr[N-1:0] == rptr[N-1:0]) && (wptr[N] != rptr[N]);
    assign level = wptr - rptr;

    assign wa = we & (~full | re);
    assign ra = re & ~empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wa) begin
                wptr <= wptr + 1'b1;
            end
            if (ra) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            ovf <= ovf | (we & full & ~re);
            udf <= udf | (re & empty);
        end
    end
`endif

    fifo_v1_ram #(
        .W(W),
        .N(N)
    ) u_ram (
        .clk(clk),
        .we (wa),
        .wa (wptr[N-1:0]),
        .wd (wd),
        .ra (rptr[N-1:0]),
        .rd (rd)
    );
endmodule

// File: tb/tb_fifo_v1.sv
// Bench for fifo_v1 (W=4, N=2): directed steps plus random traffic against a queue model.
// Build with FIFO_ERR_FLAGS_EN defined to also check the sticky ovf/udf flags.
module tb_fifo_v1;
    localparam int TW    = 4;
    localparam int TN    = 2;
    localparam int DEPTH = 4;

    logic          clk;
    logic          rst_n;
    logic          we;
    logic [TW-1:0] wd;
    logic          re;
    logic [TW-1:0] rd;
    logic          empty;
    logic          full;
    logic [TN:0]   level;
`ifdef FIFO_ERR_FLAGS_EN
    logic          ovf;
    logic          udf;
`endif

    fifo_v1 #(
        .W(TW),
        .N(TN)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (we),
        .wd   (wd),
        .re   (re),
        .rd   (rd),
        .empty(empty),
        .full (full),
`ifdef FIFO_ERR_FLAGS_EN
        .ovf  (ovf),
        .udf  (udf),
`endif
        .level(level)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // scoreboard: reference queue and sticky error model
    logic [TW-1:0] exp_q[$];
    logic          exp_ovf;
    logic          exp_udf;
    int            n_cmp;
    int            n_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".empty"}, 32'(empty), 32'(exp_q.size() == 0));
        chk({tag, ".full"},  32'(full),  32'(exp_q.size() == DEPTH));
        chk({tag, ".level"}, 32'(level), 32'(exp_q.size()));
        if (exp_q.size() != 0) begin
            chk({tag, ".rd"}, 32'(rd), 32'(exp_q[0]));
        end
`ifdef FIFO_ERR_FLAGS_EN
        chk({tag, ".ovf"}, 32'(ovf), 32'(exp_ovf));
        chk({tag, ".udf"}, 32'(udf), 32'(exp_udf));
`endif
    endtask

    // driver: apply one cycle of requests, update the model at the edge, check on the falling edge
    task automatic step(input logic w, input logic [TW-1:0] d, input logic r, input string tag);
        bit was_full;
        bit was_empty;
        we = w;
        wd = d;
        re = r;
        @(posedge clk);
        was_full  = (exp_q.size() == DEPTH);
        was_empty = (exp_q.size() == 0);
        if (w && was_full && !r) exp_ovf = 1'b1;
        if (r && was_empty)      exp_udf = 1'b1;
        if (r && !was_empty)     void'(exp_q.pop_front());
        if (w && (!was_full || r)) exp_q.push_back(d);
        @(negedge clk);
        we = 1'b0;
        re = 1'b0;
        check_all(tag);
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_ovf = 1'b0;
        exp_udf = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        we    = 1'b0;
        re    = 1'b0;
        wd    = '0;
        rst_n = 1'b0;
        model_reset();

        // reset held for 100 ns, released away from the active edge
        #100;
        @(negedge clk);
        rst_n = 1'b1;
        check_all("reset");

        // fill 0..3
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, TW'(i), 1'b0, "fill");
        end
        // write into full FIFO without read is dropped
        step(1'b1, 4'hF, 1'b0, "overflow");
        step(1'b0, 4'h0, 1'b0, "overflow_hold");
        // simultaneous read/write while full: pop oldest, append 9
        step(1'b1, 4'h9, 1'b1, "full_rw");
        // drain
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 4'h0, 1'b1, "drain");
        end
        // read while empty is dropped
        step(1'b0, 4'h0, 1'b1, "underflow");
        // simultaneous read/write while empty: write only
        step(1'b1, 4'h6, 1'b1, "empty_rw");
        step(1'b0, 4'h0, 1'b1, "empty_rw_pop");

        // ten write/read pairs so both pointers wrap
        for (int i = 0; i < 10; i++) begin
            step(1'b1, TW'($urandom_range(0, 15)), 1'b0, "wrap_w");
            step(1'b0, 4'h0, 1'b1, "wrap_r");
        end

        // random traffic, alternating write-heavy and read-heavy phases
        for (int i = 0; i < 400; i++) begin
            int wbias;
            wbias = ((i / 40) % 2 == 0) ? 3 : 1;
            step($urandom_range(0, 3) < wbias, TW'($urandom_range(0, 15)),
                 $urandom_range(0, 3) >= wbias, "random");
        end

        // mid-stream reset must flush without a clock edge
        for (int i = 0; i < 3; i++) begin
            step(1'b1, TW'(i + 5), 1'b0, "pre_rst");
        end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        check_all("post_rst");
        step(1'b1, 4'hA, 1'b0, "after_rst_w");
        step(1'b0, 4'h0, 1'b1, "after_rst_r");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
